mem_access_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage. It consumes the EX/MEM register contents and performs load/store accesses to data memory over a request/acknowledge interface, handling byte-lane alignment and stalls. It selects the writeback result from the ALU, multiplier, divider or load data, and drives the MEM/WB register. It raises mem_hold to freeze the upstream pipeline while an access is outstanding.

---
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory request/ack bus for loads and
// stores, aligns byte lanes, picks the writeback result and registers MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_regwrite,
  input  logic [4:0]  EX_MEM_rd,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_mulres,
  input  logic        EX_MEM_mul_ready,
  input  logic [31:0] EX_MEM_divres,
  input  logic        EX_MEM_div_ready,
  input  logic [31:0] EX_MEM_dout_rs2,
  input  logic [4:0]  EX_MEM_loadcntrl,
  input  logic [2:0]  EX_MEM_storecntrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_hold,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_res,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             timeout_q, timeout_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_err_q, misalign_err_d;
  logic             wb_regwrite_q, wb_regwrite_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_res_q, wb_res_d;

  logic [1:0]  off;
  logic        is_lb, is_lh, is_lw, is_lbu, is_lhu;
  logic        is_sb, is_sh, is_sw;
  logic        ld_mis, st_mis, misaligned, access, in_wait, wb_en;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign off    = EX_MEM_alures[1:0];
  assign is_lb  = EX_MEM_loadcntrl[0];
  assign is_lh  = EX_MEM_loadcntrl[1];
  assign is_lw  = EX_MEM_loadcntrl[2];
  assign is_lbu = EX_MEM_loadcntrl[3];
  assign is_lhu = EX_MEM_loadcntrl[4];
  assign is_sb  = EX_MEM_storecntrl[0];
  assign is_sh  = EX_MEM_storecntrl[1];
  assign is_sw  = EX_MEM_storecntrl[2];

  // Alignment is only judged for the access actually requested this cycle.
  assign ld_mis     = ((is_lh | is_lhu) & off[0]) | (is_lw & (off != 2'b00));
  assign st_mis     = (is_sh & off[0]) | (is_sw & (off != 2'b00));
  assign misaligned = (EX_MEM_memread & ld_mis) | (EX_MEM_memwrite & st_mis);
  assign access     = (EX_MEM_memread | EX_MEM_memwrite) & ~misaligned;
  assign mem_hold   = access & (state_q != ST_DONE);
  assign wb_en      = ~dbg & ~mem_hold;
  assign in_wait    = (state_q == ST_WAIT);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = EX_MEM_dout_rs2;
    if (is_sb) begin
      st_be    = 4'b0001 << off;
      st_wdata = {4{EX_MEM_dout_rs2[7:0]}};
    end else if (is_sh) begin
      st_be    = off[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{EX_MEM_dout_rs2[15:0]}};
    end
  end

  // Bus outputs are live only in WAIT; upstream is frozen then, so they stay stable.
  assign dmem_req   = in_wait;
  assign dmem_we    = in_wait & EX_MEM_memwrite;
  assign dmem_addr  = in_wait ? {EX_MEM_alures[31:2], 2'b00} : 32'd0;
  assign dmem_be    = in_wait ? st_be : 4'b0000;
  assign dmem_wdata = (in_wait & EX_MEM_memwrite) ? st_wdata : 32'd0;

  always_comb begin
    case (off)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half   = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = rdata_q;
    if (is_lb)       load_data = {{24{ld_byte[7]}}, ld_byte};
    else if (is_lbu) load_data = {24'd0, ld_byte};
    else if (is_lh)  load_data = {{16{ld_half[15]}}, ld_half};
    else if (is_lhu) load_data = {16'd0, ld_half};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    bus_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access & ~dbg) begin
          state_d   = ST_WAIT;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = 32'd0;
          timeout_d = 1'b1;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (~dbg) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A timed-out load must not retire its (zeroed) data into the register file.
  always_comb begin
    wb_regwrite_d  = wb_regwrite_q;
    wb_rd_d        = wb_rd_q;
    wb_res_d       = wb_res_q;
    misalign_err_d = 1'b0;
    if (wb_en) begin
      wb_rd_d        = EX_MEM_rd;
      wb_regwrite_d  = EX_MEM_regwrite & ~misaligned & ~(EX_MEM_memread & timeout_q);
      misalign_err_d = misaligned;
      if (EX_MEM_memread)        wb_res_d = load_data;
      else if (EX_MEM_mul_ready) wb_res_d = EX_MEM_mulres;
      else if (EX_MEM_div_ready) wb_res_d = EX_MEM_divres;
      else                       wb_res_d = EX_MEM_alures;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rdata_q        <= 32'd0;
      timeout_q      <= 1'b0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_res_q       <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rdata_q        <= rdata_d;
      timeout_q      <= timeout_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_res_q       <= wb_res_d;
    end
  end

  assign MEM_WB_regwrite = wb_regwrite_q;
  assign MEM_WB_rd       = wb_rd_q;
  assign MEM_WB_res      = wb_res_q;
  assign misalign_err    = misalign_err_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model drives per-cycle expectations,
// one negedge compare process checks them, plus literal pins on key results.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  localparam logic [4:0] LB = 5'b00001, LH = 5'b00010, LW = 5'b00100, LBU = 5'b01000, LHU = 5'b10000;
  localparam logic [2:0] SB = 3'b001, SH = 3'b010, SW = 3'b100;

  logic clk = 1'b0;
  logic Rst, dbg;
  logic EX_MEM_memread, EX_MEM_memwrite, EX_MEM_regwrite;
  logic [4:0] EX_MEM_rd;
  logic [31:0] EX_MEM_alures, EX_MEM_mulres, EX_MEM_divres, EX_MEM_dout_rs2;
  logic EX_MEM_mul_ready, EX_MEM_div_ready;
  logic [4:0] EX_MEM_loadcntrl;
  logic [2:0] EX_MEM_storecntrl;
  logic dmem_req, dmem_we, dmem_ack, mem_hold;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;
  logic MEM_WB_regwrite, misalign_err, bus_err;
  logic [4:0] MEM_WB_rd;
  logic [31:0] MEM_WB_res;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg),
    .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memwrite(EX_MEM_memwrite),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_alures(EX_MEM_alures), .EX_MEM_mulres(EX_MEM_mulres),
    .EX_MEM_mul_ready(EX_MEM_mul_ready), .EX_MEM_divres(EX_MEM_divres),
    .EX_MEM_div_ready(EX_MEM_div_ready), .EX_MEM_dout_rs2(EX_MEM_dout_rs2),
    .EX_MEM_loadcntrl(EX_MEM_loadcntrl), .EX_MEM_storecntrl(EX_MEM_storecntrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_hold(mem_hold),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_res(MEM_WB_res),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] alures;
    logic [31:0] mulres;
    logic        mul_ready;
    logic [31:0] divres;
    logic        div_ready;
    logic [31:0] rs2;
    logic [4:0]  loadc;
    logic [2:0]  storec;
  } op_t;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic        exp_hold = 0, exp_req = 0, exp_we = 0, exp_bus_err = 0, exp_mis = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  logic        exp_wb_regwrite = 0, exp_res_valid = 1;
  logic [4:0]  exp_wb_rd = 0;
  logic [31:0] exp_wb_res = 0;

  logic        pin_zero = 0, pin_res_en = 0, pin_st_en = 0;
  logic [31:0] pin_res = 0, pin_addr = 0, pin_wdata = 0;
  logic [3:0]  pin_be = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_hold", 32'(mem_hold), 32'(exp_hold));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("dmem_we", 32'(dmem_we), 32'(exp_we));
      chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
      chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
      if (exp_req) chk("dmem_addr", dmem_addr, exp_addr);
      if (exp_we) begin
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      chk("wb_regwrite", 32'(MEM_WB_regwrite), 32'(exp_wb_regwrite));
      chk("wb_rd", 32'(MEM_WB_rd), 32'(exp_wb_rd));
      if (exp_res_valid) chk("wb_res", MEM_WB_res, exp_wb_res);
      if (pin_res_en) chk("pin_res", MEM_WB_res, pin_res);
      if (pin_st_en && dmem_req) begin
        chk("pin_addr", dmem_addr, pin_addr);
        chk("pin_be", 32'(dmem_be), 32'(pin_be));
        chk("pin_wdata", dmem_wdata, pin_wdata);
      end
      if (pin_zero) begin
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
      end
    end
  end

  // Access width in bytes, from whichever control field the op uses.
  function automatic int m_size(op_t o);
    if (o.memwrite) return o.storec[0] ? 1 : (o.storec[1] ? 2 : 4);
    return (o.loadc[0] | o.loadc[3]) ? 1 : ((o.loadc[1] | o.loadc[4]) ? 2 : 4);
  endfunction

  function automatic bit m_mis(op_t o);
    if (!(o.memread || o.memwrite)) return 1'b0;
    return (int'(o.alures[1:0]) % m_size(o)) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, op_t o);
    logic [31:0] w_sh;
    w_sh = w >> (8 * int'(o.alures[1:0]));
    if (o.loadc[0]) return {{24{w_sh[7]}}, w_sh[7:0]};
    if (o.loadc[3]) return {24'd0, w_sh[7:0]};
    if (o.loadc[1]) return {{16{w_sh[15]}}, w_sh[15:0]};
    if (o.loadc[4]) return {16'd0, w_sh[15:0]};
    return w;
  endfunction

  function automatic logic [3:0] m_be(op_t o);
    int sz;
    logic [3:0] mask;
    sz = m_size(o);
    mask = (sz == 1) ? 4'h1 : ((sz == 2) ? 4'h3 : 4'hF);
    return mask << o.alures[1:0];
  endfunction

  function automatic logic [31:0] m_wdata(op_t o);
    int sz;
    sz = m_size(o);
    if (sz == 1) return {4{o.rs2[7:0]}};
    if (sz == 2) return {2{o.rs2[15:0]}};
    return o.rs2;
  endfunction

  function automatic op_t mk_load(logic [4:0] kind, logic [31:0] addr, logic [4:0] rd);
    op_t o = '0;
    o.memread = 1'b1; o.regwrite = 1'b1; o.rd = rd; o.alures = addr; o.loadc = kind;
    o.mulres = 32'h1111_0000; o.divres = 32'h2222_0000;
    return o;
  endfunction

  function automatic op_t mk_store(logic [2:0] kind, logic [31:0] addr, logic [31:0] rs2);
    op_t o = '0;
    o.memwrite = 1'b1; o.alures = addr; o.rs2 = rs2; o.storec = kind;
    return o;
  endfunction

  function automatic op_t mk_alu(logic [4:0] rd, logic [31:0] alu, logic [31:0] mul, logic mrdy,
                                 logic [31:0] dv, logic drdy);
    op_t o = '0;
    o.regwrite = 1'b1; o.rd = rd; o.alures = alu;
    o.mulres = mul; o.mul_ready = mrdy; o.divres = dv; o.div_ready = drdy;
    return o;
  endfunction

  task automatic drive(input op_t o);
    EX_MEM_memread = o.memread; EX_MEM_memwrite = o.memwrite; EX_MEM_regwrite = o.regwrite;
    EX_MEM_rd = o.rd; EX_MEM_alures = o.alures; EX_MEM_mulres = o.mulres;
    EX_MEM_mul_ready = o.mul_ready; EX_MEM_divres = o.divres; EX_MEM_div_ready = o.div_ready;
    EX_MEM_dout_rs2 = o.rs2; EX_MEM_loadcntrl = o.loadc; EX_MEM_storecntrl = o.storec;
  endtask

  // ack_lat: WAIT cycle (0-based) carrying the ack, negative = never acked.
  // park: DONE cycles spent with dbg high (dbg also held through WAIT).
  task automatic run_op(input op_t o, input int ack_lat, input logic [31:0] rdata, input int park);
    bit mis, mem, tmo;
    int n_wait, total;
    mis = m_mis(o);
    mem = (o.memread || o.memwrite) && !mis;
    tmo = mem && (ack_lat < 0 || ack_lat >= TIMEOUT);
    n_wait = tmo ? TIMEOUT : ack_lat + 1;
    total = mem ? n_wait + 2 + park : 1;
    drive(o);
    for (int c = 0; c < total; c++) begin
      dmem_ack    = mem && !tmo && (c == ack_lat + 1);
      dmem_rdata  = dmem_ack ? rdata : (32'hA5A5_5A5A ^ 32'(c));
      dbg         = (park > 0) && (c >= 1) && (c < total - 1);
      exp_hold    = mem && (c <= n_wait);
      exp_req     = mem && (c >= 1) && (c <= n_wait);
      exp_we      = exp_req && o.memwrite;
      exp_addr    = o.alures & ~32'h3;
      exp_be      = m_be(o);
      exp_wdata   = m_wdata(o);
      exp_bus_err = tmo && (c == n_wait + 1);
      @(posedge clk); #1;
      pin_res_en = 1'b0;
      exp_mis = (c == total - 1) && mis;
      if (c == total - 1) begin
        exp_wb_rd = o.rd;
        exp_wb_regwrite = o.regwrite && !mis && !(o.memread && tmo);
        if (o.memread) begin
          exp_res_valid = !mis;
          exp_wb_res = tmo ? 32'd0 : m_load(rdata, o);
        end else begin
          exp_res_valid = 1'b1;
          exp_wb_res = o.mul_ready ? o.mulres : (o.div_ready ? o.divres : o.alures);
        end
      end
    end
    dmem_ack = 1'b0;
    dbg = 1'b0;
    $display("op rd=%0d addr=%h rd/wr=%0b%0b mis=%0b tmo=%0b park=%0d cycles=%0d exp_res=%h",
             o.rd, o.alures, o.memread, o.memwrite, mis, tmo, park, total, exp_wb_res);
  endtask

  // Hold an op under dbg: nothing may advance, MEM/WB keeps its value.
  task automatic idle_dbg(input op_t o, input int n);
    bit mem;
    mem = (o.memread || o.memwrite) && !m_mis(o);
    drive(o);
    dbg = 1'b1;
    for (int c = 0; c < n; c++) begin
      dmem_ack = 1'b0;
      exp_hold = mem; exp_req = 1'b0; exp_we = 1'b0; exp_bus_err = 1'b0;
      @(posedge clk); #1;
      exp_mis = 1'b0;
    end
    dbg = 1'b0;
    $display("dbg hold rd=%0d addr=%h cycles=%0d wb_res=%h", o.rd, o.alures, n, exp_wb_res);
  endtask

  task automatic reset_mid_wait();
    drive(mk_load(LW, 32'h300, 5'd7));
    dmem_ack = 1'b0; dbg = 1'b0;
    for (int c = 0; c < 5; c++) begin
      exp_hold = 1'b1; exp_req = (c >= 1); exp_we = 1'b0; exp_bus_err = 1'b0;
      exp_addr = 32'h300;
      @(posedge clk); #1;
      pin_res_en = 1'b0;
      exp_mis = 1'b0;
    end
    #2;
    Rst = 1'b1;
    exp_req = 1'b0; exp_hold = 1'b1; exp_bus_err = 1'b0; exp_mis = 1'b0;
    exp_wb_regwrite = 1'b0; exp_wb_rd = 5'd0; exp_wb_res = 32'd0; exp_res_valid = 1'b1;
    @(posedge clk); #1;
    Rst = 1'b0;
    $display("reset mid-WAIT addr=300");
  endtask

  initial begin
    Rst = 1'b1; dbg = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive('0);
    pin_zero = 1'b1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    Rst = 1'b0;
    pin_zero = 1'b0;

    run_op(mk_load(LW, 32'h100, 5'd5), 0, 32'hDEAD_BEEF, 0);
    pin_res = 32'hDEAD_BEEF; pin_res_en = 1'b1;
    run_op(mk_load(LB, 32'h103, 5'd6), 0, 32'h8011_2233, 0);
    pin_res = 32'hFFFF_FF80; pin_res_en = 1'b1;
    run_op(mk_load(LBU, 32'h103, 5'd7), 1, 32'h8011_2233, 0);
    pin_res = 32'h0000_0080; pin_res_en = 1'b1;
    run_op(mk_load(LHU, 32'h102, 5'd8), 2, 32'h8011_2233, 0);
    pin_res = 32'h0000_8011; pin_res_en = 1'b1;
    run_op(mk_load(LH, 32'h102, 5'd9), 0, 32'h8011_2233, 0);
    run_op(mk_load(LH, 32'h100, 5'd10), 3, 32'h8011_2233, 0);

    pin_addr = 32'h204; pin_be = 4'b1100; pin_wdata = 32'hABCD_ABCD; pin_st_en = 1'b1;
    run_op(mk_store(SH, 32'h206, 32'h1234_ABCD), 1, 32'd0, 0);
    pin_st_en = 1'b0;
    run_op(mk_store(SB, 32'h203, 32'h0000_00EF), 0, 32'd0, 0);
    run_op(mk_store(SW, 32'h208, 32'hCAFE_F00D), 2, 32'd0, 0);

    run_op(mk_load(LW, 32'h101, 5'd9), 0, 32'd0, 0);
    run_op(mk_store(SW, 32'h20A, 32'h1), 0, 32'd0, 0);
    run_op(mk_store(SH, 32'h201, 32'h2), 0, 32'd0, 0);
    run_op(mk_load(LHU, 32'h103, 5'd3), 0, 32'd0, 0);

    run_op(mk_load(LW, 32'h400, 5'd10), -1, 32'd0, 0);
    pin_res = 32'd0; pin_res_en = 1'b1;

    run_op(mk_alu(5'd11, 32'h7, 32'h42, 1'b1, 32'h99, 1'b0), 0, 32'd0, 0);
    pin_res = 32'h42; pin_res_en = 1'b1;
    run_op(mk_alu(5'd12, 32'h7, 32'h42, 1'b0, 32'h99, 1'b1), 0, 32'd0, 0);
    run_op(mk_alu(5'd13, 32'h1234, 32'h42, 1'b1, 32'h99, 1'b1), 0, 32'd0, 0);
    run_op(mk_alu(5'd13, 32'h1234, 32'h0, 1'b0, 32'h0, 1'b0), 0, 32'd0, 0);
    pin_res = 32'h1234; pin_res_en = 1'b1;
    idle_dbg(mk_alu(5'd14, 32'hAAAA, 32'h55, 1'b1, 32'h0, 1'b0), 3);
    run_op(mk_alu(5'd14, 32'hAAAA, 32'h55, 1'b1, 32'h0, 1'b0), 0, 32'd0, 0);

    idle_dbg(mk_load(LW, 32'h500, 5'd15), 2);
    run_op(mk_load(LW, 32'h500, 5'd15), 1, 32'h0102_0304, 0);
    run_op(mk_load(LW, 32'h504, 5'd16), 2, 32'h0BAD_F00D, 3);
    run_op(mk_load(LB, 32'h505, 5'd17), TIMEOUT - 1, 32'h0000_FF00, 0);
    pin_res = 32'hFFFF_FFFF; pin_res_en = 1'b1;

    reset_mid_wait();
    run_op(mk_load(LW, 32'h600, 5'd18), 0, 32'h1234_5678, 0);
    pin_res = 32'h1234_5678; pin_res_en = 1'b1;
    run_op(mk_alu(5'd1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0), 0, 32'd0, 0);
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
